// File: rtl/gpio_irq.sv
// gpio_irq: bus-mapped GPIO (input/output/bidir channels) with synchronised inputs and edge-triggered level IRQ; ports clk, reset, cs_/as_/rw/addr/wr_data -> rd_data/rdy_, gpio_in, gpio_out, gpio_io, irq
module gpio_irq #(
  parameter int IN_CH       = 8,
  parameter int OUT_CH      = 8,
  parameter int IO_CH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_,
  input  logic              as_,
  input  logic              rw,
  input  logic [2:0]        addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              rdy_,
  input  logic [IN_CH-1:0]  gpio_in,
  output logic [OUT_CH-1:0] gpio_out,
  inout  wire  [IO_CH-1:0]  gpio_io,
  output logic              irq
);
  logic              acc, wr;
  logic [31:0]       rd_d, rd_q;
  logic              rdy_q, irq_q;
  logic [OUT_CH-1:0] out_q;
  logic [IO_CH-1:0]  io_out_q, dir_q;
  logic [IN_CH-1:0]  en_q, rise_q, fall_q, stat_q, stat_d, hist_q, in_s, set, w1c;
  logic [IN_CH-1:0]  in_sync_q [SYNC_STAGES];
  logic [IO_CH-1:0]  io_sync_q [SYNC_STAGES];
  assign acc      = !cs_ && !as_;
  assign wr       = acc && !rw;
  assign in_s     = in_sync_q[SYNC_STAGES-1];
  assign rd_data  = rd_q;
  assign rdy_     = rdy_q;
  assign irq      = irq_q;
  assign gpio_out = out_q;
  for (genvar i = 0; i < IO_CH; i++) begin : g_io
    assign gpio_io[i] = dir_q[i] ? io_out_q[i] : 1'bz;
  end
  always_comb begin
    set    = (in_s & ~hist_q & rise_q) | (~in_s & hist_q & fall_q);
    w1c    = (wr && addr == 3'd7) ? wr_data[IN_CH-1:0] : '0;
    stat_d = (stat_q & ~w1c) | set;
    rd_d   = '0;
    case (addr)
      3'd0:    rd_d[IN_CH-1:0]  = in_s;
      3'd1:    rd_d[OUT_CH-1:0] = out_q;
      3'd2:    rd_d[IO_CH-1:0]  = io_sync_q[SYNC_STAGES-1];
      3'd3:    rd_d[IO_CH-1:0]  = dir_q;
      3'd4:    rd_d[IN_CH-1:0]  = en_q;
      3'd5:    rd_d[IN_CH-1:0]  = rise_q;
      3'd6:    rd_d[IN_CH-1:0]  = fall_q;
      default: rd_d[IN_CH-1:0]  = stat_q;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q     <= '0;
      rdy_q    <= 1'b1;
      irq_q    <= 1'b0;
      out_q    <= '0;
      io_out_q <= '0;
      dir_q    <= '0;
      en_q     <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      stat_q   <= '0;
      hist_q   <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        in_sync_q[s] <= '0;
        io_sync_q[s] <= '0;
      end
    end else begin
      rd_q   <= (acc && rw) ? rd_d : '0;
      rdy_q  <= !acc;
      irq_q  <= |(stat_q & en_q);
      stat_q <= stat_d;
      hist_q <= in_s;
      in_sync_q[0] <= gpio_in;
      io_sync_q[0] <= gpio_io;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        in_sync_q[s] <= in_sync_q[s-1];
        io_sync_q[s] <= io_sync_q[s-1];
      end
      if (wr) begin
        case (addr)
          3'd1:    out_q    <= wr_data[OUT_CH-1:0];
          3'd2:    io_out_q <= wr_data[IO_CH-1:0];
          3'd3:    dir_q    <= wr_data[IO_CH-1:0];
          3'd4:    en_q     <= wr_data[IN_CH-1:0];
          3'd5:    rise_q   <= wr_data[IN_CH-1:0];
          3'd6:    fall_q   <= wr_data[IN_CH-1:0];
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_gpio_irq.sv
// tb_gpio_irq: directed scoreboard bench for gpio_irq (register access, IO direction, edge interrupts, reset)
module tb_gpio_irq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs_ = 1'b1, as_ = 1'b1, rw = 1'b1;
  logic [2:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        rdy_;
  logic [7:0]  gpio_in = '0;
  logic [7:0]  gpio_out;
  wire  [7:0]  gpio_io;
  logic [7:0]  io_drv = '0, io_en = '0;
  logic        irq;
  int          total = 0, bad = 0;
  logic [31:0] sbq [$];
  gpio_irq dut (
    .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_io(gpio_io), .irq(irq)
  );
  for (genvar i = 0; i < 8; i++) begin : g_drv
    assign gpio_io[i] = io_en[i] ? io_drv[i] : 1'bz;
  end
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = a; wr_data = d;
    tick();
    cs_ = 1'b1; as_ = 1'b1; rw = 1'b1;
    chk("wr_rdy", 32'(rdy_), 32'd0);
  endtask
  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string tag);
    int n = 0;
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = a;
    sbq.push_back(e);
    tick();
    cs_ = 1'b1; as_ = 1'b1;
    while (rdy_ !== 1'b0 && n < 4) begin
      tick();
      n++;
    end
    chk({tag, "_rdy"}, 32'(rdy_), 32'd0);
    chk(tag, rd_data, sbq.pop_front());
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = 3'd3; wr_data = 32'hFF;
    tick(2);
    chk("rst_rdy", 32'(rdy_), 32'd1);
    chk("rst_rd", rd_data, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_out", 32'(gpio_out), 32'd0);
    cs_ = 1'b1; as_ = 1'b1; rw = 1'b1;
    io_en = 8'hFF; io_drv = 8'hA5;
    reset = 1'b0;
    tick(3);
    chk("rst_pins", 32'(gpio_io), 32'hA5);
    rd(3'd2, 32'hA5, "rst_io_rd");
    rd(3'd3, 32'h0, "rst_dir");
    io_en = 8'h00;
    wr(3'd1, 32'hA5);
    chk("out_a5", 32'(gpio_out), 32'hA5);
    rd(3'd1, 32'hA5, "rd_out");
    tick();
    chk("idle_rd", rd_data, 32'd0);
    chk("idle_rdy", 32'(rdy_), 32'd1);
    wr(3'd1, 32'hFFFF_FF5A);
    rd(3'd1, 32'h5A, "out_mask");
    wr(3'd0, 32'hFF);
    gpio_in = 8'h3C;
    tick(3);
    rd(3'd0, 32'h3C, "in_data");
    gpio_in = 8'h00;
    tick(4);
    wr(3'd3, 32'h0F);
    wr(3'd2, 32'hFF);
    io_en = 8'hF0; io_drv = 8'h30;
    tick(2);
    chk("io_pins", 32'(gpio_io), 32'h3F);
    rd(3'd2, 32'h3F, "io_rd");
    rd(3'd3, 32'h0F, "dir_rd");
    io_en = 8'h00;
    wr(3'd3, 32'h0);
    wr(3'd4, 32'h1);
    wr(3'd5, 32'h1);
    rd(3'd7, 32'h0, "stat_idle");
    gpio_in = 8'h01;
    tick(2);
    chk("irq_c2", 32'(irq), 32'd0);
    tick();
    chk("irq_c3", 32'(irq), 32'd0);
    tick();
    chk("irq_c4", 32'(irq), 32'd1);
    rd(3'd7, 32'h1, "stat_rise");
    rd(3'd7, 32'h1, "stat_noclr");
    wr(3'd7, 32'h1);
    chk("irq_w1c_hold", 32'(irq), 32'd1);
    tick();
    chk("irq_w1c", 32'(irq), 32'd0);
    rd(3'd7, 32'h0, "stat_clr");
    gpio_in = 8'h03;
    tick(4);
    wr(3'd4, 32'h0);
    wr(3'd5, 32'h0);
    wr(3'd6, 32'h2);
    rd(3'd7, 32'h0, "stat_pre_fall");
    gpio_in = 8'h01;
    tick(4);
    rd(3'd7, 32'h2, "stat_fall");
    chk("irq_fall_dis", 32'(irq), 32'd0);
    wr(3'd4, 32'h2);
    chk("irq_en_lag", 32'(irq), 32'd0);
    tick();
    chk("irq_en", 32'(irq), 32'd1);
    wr(3'd7, 32'h2);
    tick();
    chk("irq_fall_clr", 32'(irq), 32'd0);
    wr(3'd6, 32'h0);
    wr(3'd4, 32'h1);
    wr(3'd5, 32'h1);
    gpio_in = 8'h00;
    tick(4);
    gpio_in = 8'h01;
    tick(4);
    gpio_in = 8'h00;
    tick(4);
    rd(3'd7, 32'h1, "stat_pre_race");
    gpio_in = 8'h01;
    tick(2);
    wr(3'd7, 32'h1);
    rd(3'd7, 32'h1, "w1c_race");
    wr(3'd7, 32'h1);
    rd(3'd7, 32'h0, "w1c_after");
    gpio_in = 8'h05;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wr(3'd5, 32'h4);
    tick(2);
    rd(3'd7, 32'h4, "post_rst_rise");
    chk("post_rst_irq", 32'(irq), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gpio_irq.md
GPIO_IRQ -- requirements
Module: gpio_irq

Interface
REQ-001 Parameter IN_CH, default 8: input-only channel count, 1..32.
REQ-002 Parameter OUT_CH, default 8: output-only channel count, 1..32.
REQ-003 Parameter IO_CH, default 8: bidirectional channel count, 1..32.
REQ-004 Parameter SYNC_STAGES, default 2: input synchroniser depth, 2..3.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 cs_  in  1  chip select, active low.
REQ-008 as_  in  1  address strobe, active low.
REQ-009 rw  in  1  1 = read, 0 = write.
REQ-010 addr  in  3  word register index.
REQ-011 wr_data  in  32  write data.
REQ-012 rd_data  out  32  read data.
REQ-013 rdy_  out  1  access acknowledge, active low.
REQ-014 gpio_in  in  IN_CH  asynchronous input pins.
REQ-015 gpio_out  out  OUT_CH  output pins.
REQ-016 gpio_io  inout  IO_CH  bidirectional pins.
REQ-017 irq  out  1  level interrupt, active high.

Function
REQ-018 Access = cs_ low AND as_ low in a cycle; rdy_ SHALL be low exactly in the following cycle, high otherwise.
REQ-019 Read: rd_data SHALL hold the addressed register (zero-extended) in the cycle rdy_ is low, and all-zero in every other cycle.
REQ-020 Write: the register SHALL update on the access edge; wr_data bits above channel width ignored.
REQ-021 Map: 0 IN_DATA (RO, synchronised gpio_in), 1 OUT_DATA (RW), 2 IO_DATA (read = synchronised pins, write = io_out), 3 IO_DIR (RW, 1 = output), 4 IRQ_EN (RW), 5 IRQ_RISE (RW), 6 IRQ_FALL (RW), 7 IRQ_STAT (read; write-1-to-clear).
REQ-022 Unmapped bits SHALL read 0; writes to read-only bits SHALL have no effect.
REQ-023 gpio_in and gpio_io SHALL each pass through SYNC_STAGES flops, plus one history flop for edge detection.
REQ-024 Pin gpio_io[i] SHALL drive io_out[i] when IO_DIR[i]=1, high-impedance otherwise.
REQ-025 IRQ sources: IN_CH input channels, bits [IN_CH-1:0] of IRQ_* registers.
REQ-026 STAT[i] SHALL set when the synchronised input shows 0->1 with RISE[i]=1, or 1->0 with FALL[i]=1; both set = both edges.
REQ-027 STAT[i] SHALL set independently of EN[i]; EN gates only irq.
REQ-028 Same-cycle edge set and W1C clear on one bit: set SHALL win.
REQ-029 irq SHALL be registered: irq = OR(STAT & EN) of the previous cycle state, one cycle after STAT change.
REQ-030 Pin edge to STAT set latency SHALL be SYNC_STAGES+1 cycles; to irq, SYNC_STAGES+2.
REQ-031 Reads SHALL not alter any state (no clear-on-read).
REQ-032 Access held across consecutive cycles SHALL be treated as one access per cycle; write effects idempotent except STAT.

Reset
REQ-033 While reset=1 on a clock edge: rd_data=0, rdy_=1, irq=0, OUT_DATA, io_out, IO_DIR, EN, RISE, FALL, STAT all 0, sync and history flops 0.
REQ-034 Reset SHALL override an access in the same cycle; no write takes effect.
REQ-035 First cycle after reset the history flop is 0, so a pin held high SHALL produce a rising event if RISE enabled.

Verification
REQ-036 Write addr1 = 0xA5 -> gpio_out=0xA5 next cycle; read addr1 -> rd_data=0x000000A5 with rdy_ low one cycle later.
REQ-037 IO_DIR=0x0F, io_out=0xFF, external drives gpio_io[7:4]=0x3 -> pins[3:0]=0xF driven, [7:4] Z; read addr2 after 2 cycles = 0x3F.
REQ-038 EN=0x01, RISE=0x01, gpio_in[0] 0->1 -> STAT[0]=1 at cycle 3, irq=1 at cycle 4; W1C 0x01 -> irq=0 next cycle.
REQ-039 FALL=0x02, EN=0, gpio_in[1] 1->0 -> STAT=0x02, irq stays 0; then EN=0x02 -> irq=1 next cycle.
REQ-040 W1C on STAT[0] same cycle as new rising edge on bit 0 -> STAT[0] remains 1.
REQ-041 Reset asserted during a write to addr3 -> IO_DIR=0, rdy_=1, all pins Z.
